// File: rtl/counter_5bit_ctrl_if.sv
// Purpose: bundles the session handshake, the counter control/status lines and the result outputs of counter_5bit_ctrl.
// Latency: none; wires only.
// Backpressure: drain_ready gates draining; there is no other flow control.
// Ports (slave = controller side):
//   in  : start, in_valid, stop, drain_ready, down_done, result[4:0]
//   out : cntU, cntD, rst5, busy, full, overflow, out_pulse, done, total[4:0], drained[4:0]
interface counter_5bit_ctrl_if;
  logic       start;
  logic       in_valid;
  logic       stop;
  logic       drain_ready;
  logic       down_done;
  logic [4:0] result;
  logic       cntU;
  logic       cntD;
  logic       rst5;
  logic       busy;
  logic       full;
  logic       overflow;
  logic       out_pulse;
  logic       done;
  logic [4:0] total;
  logic [4:0] drained;

  // Environment side: session stimulus plus the external up/down counter.
  modport master (
    output start, in_valid, stop, drain_ready, down_done, result,
    input  cntU, cntD, rst5, busy, full, overflow, out_pulse, done, total, drained
  );

  // Controller side.
  modport slave (
    input  start, in_valid, stop, drain_ready, down_done, result,
    output cntU, cntD, rst5, busy, full, overflow, out_pulse, done, total, drained
  );
endinterface

// File: rtl/counter_5bit_ctrl.sv
// Purpose: session controller for an external 5-bit up/down counter: clear, count items up, then drain them back down.
// Latency: cntU/cntD/out_pulse/full are combinational in the same cycle; total, drained and overflow update on the next edge.
// Backpressure: a drained item leaves only when drain_ready=1; in_valid at full is dropped and flagged via sticky overflow.
// Ports: clk, rst_n (async, active-low), bus (counter_5bit_ctrl_if.slave).
module counter_5bit_ctrl (
  input logic                clk,
  input logic                rst_n,
  counter_5bit_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    COUNT = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       full_c;
  logic       cnt_up_c;
  logic       cnt_dn_c;
  logic       overflow_q;
  logic [4:0] total_q;
  logic [4:0] drained_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // All counter requests are decoded from the current state, so an async
  // reset (state -> IDLE) drops cntU/cntD in the same cycle.
  always_comb begin
    state_nxt = state;
    full_c    = 1'b0;
    cnt_up_c  = 1'b0;
    cnt_dn_c  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        state_nxt = COUNT;
      end
      COUNT: begin
        full_c = (bus.result == 5'd31);
        // stop wins over a simultaneous item; saturate instead of wrapping.
        cnt_up_c = bus.in_valid & ~full_c & ~bus.stop;
        if (bus.stop) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Never decrement at zero, so the counter cannot underflow to 31.
        cnt_dn_c = bus.drain_ready & ~bus.down_done;
        if (bus.down_done) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      total_q    <= 5'd0;
      drained_q  <= 5'd0;
    end else begin
      case (state)
        CLEAR: begin
          overflow_q <= 1'b0;
          total_q    <= 5'd0;
          drained_q  <= 5'd0;
        end
        COUNT: begin
          if (bus.stop) begin
            total_q <= bus.result;
          end else if (bus.in_valid && full_c) begin
            overflow_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (cnt_dn_c) begin
            drained_q <= drained_q + 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.cntU      = cnt_up_c;
  assign bus.cntD      = cnt_dn_c;
  assign bus.out_pulse = cnt_dn_c;
  assign bus.full      = full_c;
  assign bus.rst5      = (state == CLEAR);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == FIN);
  assign bus.overflow  = overflow_q;
  assign bus.total     = total_q;
  assign bus.drained   = drained_q;

endmodule

// File: tb/tb_counter_5bit_ctrl.sv
// Purpose: self-checking bench for counter_5bit_ctrl with a 5-bit up/down counter model attached.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1-2 units later or on negedge.
// Backpressure: drain_ready driven always-on or alternating per session vector.
module tb_counter_5bit_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  counter_5bit_ctrl_if ifc ();

  counter_5bit_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  // External counter: synchronous clear, saturation left to the controller,
  // not touched by rst_n.
  logic [4:0] cnt = 5'd0;
  always @(posedge clk) begin
    if (ifc.rst5)      cnt <= 5'd0;
    else if (ifc.cntU) cnt <= cnt + 5'd1;
    else if (ifc.cntD) cnt <= cnt - 5'd1;
  end
  assign ifc.result    = cnt;
  assign ifc.down_done = (cnt == 5'd0);

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    int n_items;          // in_valid pulses before stop
    bit with_stop;        // in_valid held high in the stop cycle too
    bit alt_drain;        // drain_ready 1,0,1,0... instead of constant 1
    bit start_busy;       // hold start high while counting
    int exp_total;
    bit exp_ovf;
    int exp_drain_cycles; // DRAIN-cycle index at which done is first seen
  } vec_t;

  typedef struct {
    logic [4:0] total;
    logic       ovf;
    int         pulses;
  } sb_t;

  sb_t sb[$];
  sb_t sb_r;
  int  pulse_cnt = 0;
  bit  prev_done = 1'b0;

  // Output monitor: pops the scoreboard when a session completes.
  always @(negedge clk) begin
    check("updn_exclusive", int'(ifc.cntU & ifc.cntD), 0);
    if (ifc.rst5) pulse_cnt = 0;
    else if (ifc.out_pulse) pulse_cnt++;
    if (prev_done) check("done_one_cycle", int'(ifc.done), 0);
    if (ifc.done) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 0, 1);
      end else begin
        sb_r = sb.pop_front();
        check("fin_total", int'(ifc.total), int'(sb_r.total));
        check("fin_drained", int'(ifc.drained), int'(sb_r.total));
        check("fin_overflow", int'(ifc.overflow), int'(sb_r.ovf));
        check("fin_pulses", pulse_cnt, sb_r.pulses);
      end
    end
    prev_done = ifc.done;
  end

  function automatic int outs_vec();
    return int'({ifc.busy, ifc.full, ifc.overflow, ifc.out_pulse, ifc.done,
                 ifc.cntU, ifc.cntD, ifc.rst5, ifc.total, ifc.drained});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_session(input vec_t v);
    int  exp_cnt;
    int  left;
    bit  seen;
    bit  dr;
    sb.push_back('{total: 5'(v.exp_total), ovf: v.exp_ovf, pulses: v.exp_total});
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    #1;
    check("clear_rst5", int'(ifc.rst5), 1);
    check("clear_busy", int'(ifc.busy), 1);
    tick();
    check("count_rst5_low", int'(ifc.rst5), 0);
    check("count_entry_result", int'(ifc.result), 0);
    exp_cnt = 0;
    for (int i = 0; i < v.n_items; i++) begin
      ifc.in_valid = 1'b1;
      ifc.start    = v.start_busy;
      #1;
      check("count_full", int'(ifc.full), int'(exp_cnt == 31));
      check("count_cntU", int'(ifc.cntU), int'(exp_cnt < 31));
      tick();
      if (exp_cnt < 31) exp_cnt++;
    end
    ifc.start    = 1'b0;
    ifc.stop     = 1'b1;
    ifc.in_valid = v.with_stop;
    #1;
    check("stop_cntU", int'(ifc.cntU), 0);
    tick();
    ifc.stop     = 1'b0;
    ifc.in_valid = 1'b0;
    check("drain_total", int'(ifc.total), v.exp_total);
    check("drain_full_low", int'(ifc.full), 0);
    left = v.exp_total;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      dr = v.alt_drain ? (c % 2 == 0) : 1'b1;
      ifc.drain_ready = dr;
      #1;
      if (ifc.done) begin
        seen = 1'b1;
        check("drain_cycles", c, v.exp_drain_cycles);
      end else begin
        check("drain_out_pulse", int'(ifc.out_pulse), int'(dr && left > 0));
        if (dr && left > 0) left--;
        tick();
      end
    end
    if (!seen) check("drain_timeout", 0, 1);
    ifc.drain_ready = 1'b0;
    tick();
    check("idle_busy", int'(ifc.busy), 0);
  endtask

  vec_t vecs[5];
  vec_t v6;

  initial begin
    vecs[0] = '{5,  1'b0, 1'b0, 1'b0, 5,  1'b0, 6};   // basic session
    vecs[1] = '{33, 1'b0, 1'b0, 1'b0, 31, 1'b1, 32};  // saturation + overflow
    vecs[2] = '{3,  1'b1, 1'b0, 1'b1, 3,  1'b0, 4};   // stop with in_valid; start while busy
    vecs[3] = '{0,  1'b0, 1'b0, 1'b0, 0,  1'b0, 1};   // empty session
    vecs[4] = '{4,  1'b0, 1'b1, 1'b0, 4,  1'b0, 8};   // drain_ready toggling
    v6      = '{1,  1'b0, 1'b0, 1'b0, 1,  1'b0, 2};   // session after mid-drain reset

    rst_n           = 1'b0;
    ifc.start       = 1'b0;
    ifc.in_valid    = 1'b0;
    ifc.stop        = 1'b0;
    ifc.drain_ready = 1'b0;
    tick();
    tick();
    check("reset_outputs", outs_vec(), 0);
    rst_n = 1'b1;
    tick();
    check("post_reset_busy", int'(ifc.busy), 0);

    for (int k = 0; k < 5; k++) run_session(vecs[k]);

    // Reset during DRAIN with two items still in the counter.
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    tick();
    ifc.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    ifc.in_valid = 1'b0;
    ifc.stop     = 1'b1;
    tick();
    ifc.stop        = 1'b0;
    ifc.drain_ready = 1'b1;
    tick();
    tick();
    #1;
    check("pre_reset_cntD", int'(ifc.cntD), 1);
    check("pre_reset_result", int'(ifc.result), 2);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", outs_vec(), 0);
    tick();
    check("held_reset_result", int'(ifc.result), 2);
    rst_n = 1'b1;
    ifc.drain_ready = 1'b0;
    tick();
    check("after_reset_busy", int'(ifc.busy), 0);
    check("after_reset_result", int'(ifc.result), 2);
    run_session(v6);

    tick();
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/counter_5bit_ctrl.md
COUNTER_5BIT_CTRL -- requirements
Module: counter_5bit_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-003 SHALL have port start, input, 1, begins a count/drain session; honoured only in IDLE.
REQ-004 SHALL have port in_valid, input, 1, one item to count this cycle.
REQ-005 SHALL have port stop, input, 1, ends counting phase and begins drain.
REQ-006 SHALL have port drain_ready, input, 1, consumer accepts one drained item this cycle.
REQ-007 SHALL have port down_done, input, 1, counter value is zero (from 5-bit up/down counter).
REQ-008 SHALL have port result, input, 5, current counter value.
REQ-009 SHALL have port cntU, output, 1, increment request to counter.
REQ-010 SHALL have port cntD, output, 1, decrement request to counter.
REQ-011 SHALL have port rst5, output, 1, synchronous clear request to counter.
REQ-012 SHALL have outputs busy (1), full (1), overflow (1), out_pulse (1), done (1), total (5), drained (5).

Function
REQ-013 SHALL implement FSM states IDLE, CLEAR, COUNT, DRAIN, FIN.
REQ-014 IDLE: busy=0; start=1 -> CLEAR next cycle; all other inputs ignored.
REQ-015 CLEAR: rst5=1 for exactly one cycle; clears overflow and drained to 0; -> COUNT.
REQ-016 COUNT: full = (result==31); cntU = in_valid & ~full & ~stop, combinational, same cycle.
REQ-017 COUNT: in_valid=1 while full=1 and stop=0 SHALL set sticky overflow=1; counter not incremented (no wrap to 0).
REQ-018 COUNT: stop=1 -> DRAIN next cycle; stop has priority over simultaneous in_valid (item dropped, overflow unchanged); total <= result on that edge.
REQ-019 DRAIN: cntD = drain_ready & ~down_done, combinational; out_pulse = cntD; drained increments by 1 per out_pulse.
REQ-020 DRAIN: down_done=1 -> FIN next cycle; cntD never asserted while down_done=1 (no underflow to 31).
REQ-021 FIN: done=1 for exactly one cycle; -> IDLE; total and drained hold until next CLEAR.
REQ-022 cntU and cntD SHALL never be 1 in the same cycle; neither asserted outside COUNT/DRAIN; rst5 only in CLEAR.
REQ-023 busy=1 in CLEAR, COUNT, DRAIN, FIN; full forced 0 outside COUNT.
REQ-024 start asserted while busy=1 SHALL be ignored (no restart).
REQ-025 At FIN, drained SHALL equal total.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state IDLE and busy, full, overflow, out_pulse, done, cntU, cntD, rst5 = 0; total, drained = 5'd0.
REQ-027 rst_n deassertion mid-session SHALL resume in IDLE; counter value is not cleared by this block until next CLEAR.
REQ-028 rst_n asserted during DRAIN SHALL drop cntD in the same cycle (combinational with state reset).

Verification
REQ-029 Bench SHALL instantiate block with a 5-bit up/down counter model (sync clear, down_done = result==0).
REQ-030 Scenario 1: start, 5 in_valid pulses, stop, drain_ready=1 -> total=5, 5 out_pulse cycles, done one cycle, drained=5.
REQ-031 Scenario 2: 33 in_valid pulses -> result saturates at 31, full=1, overflow=1, cntU low at full; drain yields 31 out_pulse.
REQ-032 Scenario 3: stop and in_valid same cycle after 3 items -> total=3, cntU=0 that cycle.
REQ-033 Scenario 4: start then immediate stop (0 items) -> total=0, no cntD, FIN on cycle after entering DRAIN.
REQ-034 Scenario 5: drain_ready toggled 1,0,1,0 with total=4 -> out_pulse only on drain_ready=1 cycles, done after 4th pulse.
REQ-035 Scenario 6: rst_n low during DRAIN with 2 items left -> all outputs 0 immediately, IDLE after release, start re-enters CLEAR with rst5=1.
